dvp_pattern_source: RTL

DVP_PATTERN_SOURCE -- requirements
Module: dvp_pattern_source

---
 rtl/dvp_pattern_source_pkg.sv | 31 +++
 rtl/dvp_pattern_source_gen.sv | 35 +++
 rtl/dvp_pattern_source.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/dvp_pattern_source_pkg.sv
// Shared definitions for the DVP test-pattern source: FSM state encoding,
// pattern_sel encoding and the colour-bar word table.
package dvp_pattern_source_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VSYNC  = 3'd1;
  localparam logic [2:0] ST_VBACK  = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_VFRONT = 3'd4;

  localparam logic [1:0] PAT_BARS    = 2'd0;
  localparam logic [1:0] PAT_RAMP    = 2'd1;
  localparam logic [1:0] PAT_SOLID   = 2'd2;
  localparam logic [1:0] PAT_CHECKER = 2'd3;

  // RGB565 words with red in [4:0], green in [10:5], blue in [15:11].
  function automatic logic [15:0] bar_word(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_word = 16'hFFFF;
      3'd1:    bar_word = 16'h07FF;
      3'd2:    bar_word = 16'hFFE0;
      3'd3:    bar_word = 16'h07E0;
      3'd4:    bar_word = 16'hF81F;
      3'd5:    bar_word = 16'h001F;
      3'd6:    bar_word = 16'hF800;
      3'd7:    bar_word = 16'h0000;
      default: bar_word = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/dvp_pattern_source_gen.sv
// Combinational pixel-word generator: maps (x, y, pattern, frame_cnt) to an
// RGB565 word; the timing FSM owns registering and byte selection.
module dvp_pattern_gen
  import dvp_pattern_source_pkg::*;
#(
  parameter int H_ACTIVE = 1280
) (
  input  logic [11:0] x,
  input  logic [11:0] y,
  input  logic [1:0]  pattern,
  input  logic [7:0]  frame_cnt,
  output logic [15:0] word
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] bar_idx;
  // Only y[3] selects the checker phase; the rest of y is intentionally unused.
  logic       unused_y;

  assign unused_y = ^{y[11:4], y[2:0]};

  // Select the word for the held pattern.
  always_comb begin
    bar_idx = 3'(x / 12'(BAR_W));
    case (pattern)
      PAT_BARS:    word = bar_word(bar_idx);
      PAT_RAMP:    word = {4'h0, x};
      PAT_SOLID:   word = {frame_cnt, frame_cnt};
      PAT_CHECKER: word = (x[3] ^ y[3]) ? 16'hFFFF : 16'h0000;
      default:     word = 16'h0000;
    endcase
  end

endmodule

// File: rtl/dvp_pattern_source.sv
// OV5640-style DVP pattern source: frame/line timing FSM with registered
// vsync/href/data outputs driven from the next-cycle state.
module dvp_pattern_source
  import dvp_pattern_source_pkg::*;
#(
  parameter int H_ACTIVE  = 1280,
  parameter int V_ACTIVE  = 720,
  parameter int H_BLANK   = 64,
  parameter int VSYNC_LEN = 4,
  parameter int V_BACK    = 8,
  parameter int V_FRONT   = 4
) (
  input  logic       clk,
  input  logic       rest_n,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic       dvp_vsync,
  output logic       dvp_href,
  output logic [7:0] dvp_data,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int L     = 2 * H_ACTIVE + H_BLANK;
  localparam int BYTES = 2 * H_ACTIVE;
  localparam int HW    = $clog2(L + 1);
  localparam int VW    = 16;

  logic [2:0]    state;
  logic [2:0]    next_state;
  logic [HW-1:0] hcnt;
  logic [HW-1:0] next_hcnt;
  logic [VW-1:0] vcnt;
  logic [VW-1:0] next_vcnt;
  logic [VW-1:0] phase_last;
  logic [1:0]    frame_pattern;
  logic          frame_done;
  logic          entering_vsync;
  logic          byte_phase;
  logic [15:0]   word;

  // Last line index of the current vertical phase.
  always_comb begin
    case (state)
      ST_VSYNC:  phase_last = VW'(VSYNC_LEN - 1);
      ST_VBACK:  phase_last = VW'((V_BACK > 0) ? V_BACK - 1 : 0);
      ST_ACTIVE: phase_last = VW'(V_ACTIVE - 1);
      ST_VFRONT: phase_last = VW'((V_FRONT > 0) ? V_FRONT - 1 : 0);
      default:   phase_last = '0;
    endcase
  end

  // Next state and position; a frame ends on the last cycle of VFRONT (or ACTIVE).
  always_comb begin
    next_state = state;
    next_hcnt  = hcnt;
    next_vcnt  = vcnt;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        next_hcnt = '0;
        next_vcnt = '0;
        if (enable) begin
          next_state = ST_VSYNC;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_VSYNC, ST_VBACK, ST_ACTIVE, ST_VFRONT: begin
        if (hcnt == HW'(L - 1)) begin
          next_hcnt = '0;
          if (vcnt == phase_last) begin
            next_vcnt = '0;
            case (state)
              ST_VSYNC:  next_state = (V_BACK > 0) ? ST_VBACK : ST_ACTIVE;
              ST_VBACK:  next_state = ST_ACTIVE;
              ST_ACTIVE: begin
                if (V_FRONT > 0) begin
                  next_state = ST_VFRONT;
                end else begin
                  frame_done = 1'b1;
                end
              end
              ST_VFRONT: frame_done = 1'b1;
              default:   next_state = ST_IDLE;
            endcase
            if (frame_done) begin
              next_state = enable ? ST_VSYNC : ST_IDLE;
            end else begin
              next_state = next_state;
            end
          end else begin
            next_vcnt = vcnt + VW'(1);
          end
        end else begin
          next_hcnt = hcnt + HW'(1);
        end
      end
      default: begin
        next_state = ST_IDLE;
        next_hcnt  = '0;
        next_vcnt  = '0;
      end
    endcase
  end

  // Decode of the upcoming cycle drives the registered outputs.
  always_comb begin
    entering_vsync = (next_state == ST_VSYNC) && (state != ST_VSYNC);
    byte_phase     = (next_state == ST_ACTIVE) && (next_hcnt < HW'(BYTES));
  end

  dvp_pattern_gen #(
    .H_ACTIVE (H_ACTIVE)
  ) u_gen (
    .x         (12'(next_hcnt >> 1)),
    .y         (12'(next_vcnt)),
    .pattern   (frame_pattern),
    .frame_cnt (frame_cnt),
    .word      (word)
  );

  // State, counters and registered DVP outputs.
  always_ff @(posedge clk) begin
    if (!rest_n) begin
      state         <= ST_IDLE;
      hcnt          <= '0;
      vcnt          <= '0;
      frame_pattern <= PAT_BARS;
      frame_cnt     <= 8'h00;
      frame_start   <= 1'b0;
      dvp_vsync     <= 1'b0;
      dvp_href      <= 1'b0;
      dvp_data      <= 8'h00;
    end else begin
      state       <= next_state;
      hcnt        <= next_hcnt;
      vcnt        <= next_vcnt;
      frame_start <= entering_vsync;
      dvp_vsync   <= (next_state == ST_VSYNC);
      dvp_href    <= byte_phase;
      dvp_data    <= byte_phase ? (next_hcnt[0] ? word[7:0] : word[15:8]) : 8'h00;
      if (entering_vsync) begin
        frame_pattern <= pattern_sel;
      end
      if (frame_done) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule
